// File: rtl/reg_perm_engine.sv
// Multi-channel register permutation engine: parallel load plus multi-step
// rotate-up / rotate-down / pairwise-swap / reverse commands with valid/ready.
module reg_perm_engine #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_i,
  input  logic [NCH*WIDTH-1:0]   data_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [1:0]             cmd_mode_i,
  input  logic [CNT_W-1:0]       cmd_steps_i,
  output logic [NCH*WIDTH-1:0]   data_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   abort_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    M_ROTUP = 2'b00,
    M_ROTDN = 2'b01,
    M_SWAP  = 2'b10,
    M_REV   = 2'b11
  } mode_t;

  state_t                      state;
  mode_t                       mode_r;
  logic [CNT_W-1:0]            cnt;
  logic [NCH-1:0][WIDTH-1:0]   ch;
  logic [NCH-1:0][WIDTH-1:0]   nxt;

  assign cmd_ready_o = (state == IDLE) & ~load_i;
  assign data_o      = ch;

  // Every next value is taken from the pre-edge registers, so SWAP is a true exchange.
  for (genvar g = 0; g < NCH; g++) begin : g_perm
    localparam int UP = (g + NCH - 1) % NCH;
    localparam int DN = (g + 1) % NCH;
    localparam int SW = ((g ^ 1) < NCH) ? (g ^ 1) : g;
    localparam int RV = NCH - 1 - g;
    assign nxt[g] = (mode_r == M_ROTUP) ? ch[UP] :
                    (mode_r == M_ROTDN) ? ch[DN] :
                    (mode_r == M_SWAP)  ? ch[SW] :
                                          ch[RV];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mode_r  <= M_ROTUP;
      cnt     <= '0;
      ch      <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      abort_o <= 1'b0;
    end else begin
      done_o  <= 1'b0;
      abort_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load_i) begin
            ch <= data_i;
          end else if (cmd_valid_i) begin
            mode_r <= mode_t'(cmd_mode_i);
            if (cmd_steps_i == '0) begin
              done_o <= 1'b1;
            end else begin
              cnt    <= cmd_steps_i;
              busy_o <= 1'b1;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          if (load_i) begin
            ch      <= data_i;
            busy_o  <= 1'b0;
            abort_o <= 1'b1;
            state   <= IDLE;
          end else begin
            ch  <= nxt;
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              busy_o <= 1'b0;
              done_o <= 1'b1;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_perm_engine.sv
// Scoreboard bench for reg_perm_engine: expected channel contents are queued
// at command issue and compared when done_o pulses.
module tb_reg_perm_engine;
  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_i = 1'b0;
  logic [31:0] data_i = '0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [1:0]  cmd_mode_i = '0;
  logic [3:0]  cmd_steps_i = '0;
  logic [31:0] data_o;
  logic        busy_o, done_o, abort_o;

  reg_perm_engine #(.WIDTH(WIDTH), .NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .load_i(load_i), .data_i(data_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_mode_i(cmd_mode_i), .cmd_steps_i(cmd_steps_i),
    .data_o(data_o), .busy_o(busy_o), .done_o(done_o), .abort_o(abort_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          steps;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cur;
  int         n_total = 0;
  int         n_bad = 0;
  int         busy_cnt = 0;
  int         abort_seen = 0;
  logic [7:0] m [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack_m();
    return {m[3], m[2], m[1], m[0]};
  endfunction

  task automatic model_step(input logic [1:0] md);
    logic [7:0] t [4];
    for (int i = 0; i < 4; i++) begin
      case (md)
        2'd0:    t[i] = m[(i + 3) % 4];
        2'd1:    t[i] = m[(i + 1) % 4];
        2'd2:    t[i] = m[i ^ 1];
        default: t[i] = m[3 - i];
      endcase
    end
    m = t;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      chk("done_abort_excl", {31'd0, done_o & abort_o}, 32'd0);
      if (abort_o) begin
        abort_seen++;
        busy_cnt = 0;
      end
      if (busy_o) busy_cnt++;
      if (done_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          cur = exp_q.pop_front();
          chk("done_data", data_o, cur.data);
          chk("busy_cycles", busy_cnt, cur.steps);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic do_load(input logic [31:0] d);
    load_i = 1'b1;
    data_i = d;
    #1;
    chk("ready_low_on_load", {31'd0, cmd_ready_o}, 32'd0);
    @(posedge clk); #1;
    load_i = 1'b0;
    for (int i = 0; i < 4; i++) m[i] = d[i*8 +: 8];
    chk("load_data", data_o, d);
  endtask

  task automatic issue(input logic [1:0] md, input logic [3:0] st, input bit expect_done);
    int g = 0;
    while (!cmd_ready_o && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    chk("ready_before_cmd", {31'd0, cmd_ready_o}, 32'd1);
    cmd_valid_i = 1'b1;
    cmd_mode_i  = md;
    cmd_steps_i = st;
    if (expect_done) begin
      for (int k = 0; k < int'(st); k++) model_step(md);
      exp_q.push_back('{data: pack_m(), steps: int'(st)});
    end
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while ((exp_q.size() != 0 || busy_o) && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 200) chk("wait_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) m[i] = '0;
    #12;
    chk("rst_data", data_o, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_abort", {31'd0, abort_o}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready_o}, 32'd1);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    do_load(32'h44332211);
    issue(2'd0, 4'd1, 1'b1);
    chk("rotup_busy_after_e0", {31'd0, busy_o}, 32'd1);
    wait_done();
    chk("rotup1_const", data_o, 32'h33221144);

    do_load(32'h44332211);
    issue(2'd1, 4'd5, 1'b1);
    wait_done();
    chk("rotdn5_const", data_o, 32'h11443322);

    do_load(32'h44332211);
    issue(2'd2, 4'd1, 1'b1);
    wait_done();
    chk("swap1_const", data_o, 32'h33441122);

    do_load(32'h44332211);
    issue(2'd2, 4'd2, 1'b1);
    wait_done();
    chk("swap2_const", data_o, 32'h44332211);

    do_load(32'h44332211);
    issue(2'd3, 4'd1, 1'b1);
    wait_done();
    chk("rev1_const", data_o, 32'h11223344);

    do_load(32'h44332211);
    issue(2'd0, 4'd4, 1'b1);
    wait_done();
    chk("rotup_nch_const", data_o, 32'h44332211);

    // zero-step commands and back-to-back acceptance in done cycles
    do_load(32'h44332211);
    issue(2'd0, 4'd0, 1'b1);
    chk("zero_busy", {31'd0, busy_o}, 32'd0);
    chk("zero_done", {31'd0, done_o}, 32'd1);
    chk("zero_data", data_o, 32'h44332211);
    issue(2'd1, 4'd0, 1'b1);
    chk("b2b_zero_done", {31'd0, done_o}, 32'd1);
    issue(2'd2, 4'd3, 1'b1);
    for (int g = 0; g < 20 && !done_o; g++) begin
      @(posedge clk); #1;
    end
    chk("b2b_ready_in_done", {31'd0, cmd_ready_o}, 32'd1);
    issue(2'd3, 4'd2, 1'b1);
    chk("b2b_busy", {31'd0, busy_o}, 32'd1);
    wait_done();
    chk("b2b_final", data_o, pack_m());

    // abort by load during RUN
    do_load(32'h44332211);
    issue(2'd0, 4'd10, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    load_i = 1'b1;
    data_i = 32'hDDCCBBAA;
    #1;
    chk("abort_ready_low", {31'd0, cmd_ready_o}, 32'd0);
    @(posedge clk); #1;
    load_i = 1'b0;
    chk("abort_data", data_o, 32'hDDCCBBAA);
    chk("abort_pulse", {31'd0, abort_o}, 32'd1);
    chk("abort_busy", {31'd0, busy_o}, 32'd0);
    chk("abort_no_done", {31'd0, done_o}, 32'd0);
    @(posedge clk); #1;
    chk("abort_cleared", {31'd0, abort_o}, 32'd0);
    for (int i = 0; i < 4; i++) m[i] = data_o[i*8 +: 8];

    // asynchronous reset mid-RUN with a command held through reset
    do_load(32'h44332211);
    issue(2'd0, 4'd10, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_data", data_o, 32'd0);
    chk("arst_busy", {31'd0, busy_o}, 32'd0);
    chk("arst_done", {31'd0, done_o}, 32'd0);
    chk("arst_ready", {31'd0, cmd_ready_o}, 32'd1);
    for (int i = 0; i < 4; i++) m[i] = '0;
    cmd_valid_i = 1'b1;
    cmd_mode_i  = 2'd0;
    cmd_steps_i = 4'd2;
    exp_q.push_back('{data: 32'd0, steps: 2});
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    chk("post_rst_accept", {31'd0, busy_o}, 32'd1);
    wait_done();

    chk("abort_count", abort_seen, 32'd1);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_perm_engine.md
# reg_perm_engine

Parametrised multi-channel register permutation engine. It holds NCH channels of WIDTH bits and applies a commanded permutation: rotate up, rotate down, pairwise swap or reverse. The permutation is applied for a programmable number of steps, one step per clock. It sits between a parallel load source and downstream consumers of the channel registers, and generalises the two-register exchange to N channels, four modes and multi-step commands with a valid/ready handshake.

## Interface
- WIDTH, 8, bits per channel (>=1)
- NCH, 4, channel count (>=2)
- CNT_W, 4, width of the step-count field
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- load_i  in  1  parallel load strobe
- data_i  in  NCH*WIDTH  load data; channel i at bits [i*WIDTH +: WIDTH]
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  command accept; equals (state==IDLE) & ~load_i, combinational
- cmd_mode_i  in  2  00 ROTUP, 01 ROTDN, 10 SWAP, 11 REV
- cmd_steps_i  in  CNT_W  number of steps to apply (0 allowed)
- data_o  out  NCH*WIDTH  channel registers, same packing as data_i
- busy_o  out  1  high while in RUN
- done_o  out  1  one-cycle pulse at command completion
- abort_o  out  1  one-cycle pulse when a running command is cancelled by load_i

## Operation
- Reset values: all channels 0, state IDLE, busy_o 0, done_o 0, abort_o 0. cmd_ready_o is 1 during reset while load_i is 0.
- FSM states: IDLE and RUN. Mode and step count are latched on acceptance (cmd_valid_i & cmd_ready_o). cmd_* inputs are ignored outside acceptance.
- IDLE to RUN: on acceptance with steps != 0; the internal counter is loaded with steps.
- RUN: one step is applied per edge and the counter decrements. On the edge that applies the final step: go to IDLE and set done_o.
- Steps == 0: the command is accepted, state stays IDLE, channels are unchanged, and done_o is set on the acceptance edge.
- ROTUP step: ch[i] <= ch[i-1], ch[0] <= ch[NCH-1].
- ROTDN step: ch[i] <= ch[i+1], ch[NCH-1] <= ch[0].
- SWAP step: ch[2k] <-> ch[2k+1]. For odd NCH the last channel holds.
- REV step: ch[i] <= ch[NCH-1-i].
- All channels update simultaneously from their pre-edge values. No channel ever observes another channel's same-edge update, so SWAP is a true exchange.
- load_i in IDLE: channels <= data_i. Because cmd_ready_o is 0 while load_i is high, load always wins over a same-cycle command.
- load_i in RUN: channels <= data_i, the remaining steps are discarded, state goes to IDLE, abort_o is set and done_o is not.
- Step count has no modulo reduction: ROTUP with steps=NCH runs NCH cycles and ends with the original contents.

## Timing
- Acceptance edge E0. Steps are applied at edges E1..EN (N = steps). data_o reflects step k after Ek.
- busy_o is set at E0 and cleared at EN, giving N cycles high.
- done_o is set at EN and cleared at the next edge. cmd_ready_o is high in that same cycle, so back-to-back commands are accepted with no bubble.
- Steps == 0: done_o is high for the single cycle after E0 and busy_o stays 0.
- abort_o is high for the one cycle after the aborting load edge.
- Reset asserted mid-RUN: immediate return to reset values with no done_o or abort_o. After release, the engine idles until a new command arrives.
- Outputs data_o, busy_o, done_o and abort_o are registered; only cmd_ready_o is combinational.

## Test plan
All scenarios use WIDTH=8, NCH=4 and start by loading ch3..ch0 = 44,33,22,11 (hex).
- ROTUP, steps=1 -> ch0..ch3 = 44,11,22,33; busy_o high 1 cycle; done_o pulses at E1.
- ROTDN, steps=5 -> ch0..ch3 = 22,33,44,11; busy_o high 5 cycles; done_o exactly once.
- SWAP, steps=1 -> 22,11,44,33. SWAP, steps=2 -> original 11,22,33,44. REV, steps=1 -> 44,33,22,11.
- Steps=0 -> data unchanged; busy_o stays 0; done_o pulses on the cycle after acceptance. Back-to-back commands accepted on consecutive done cycles.
- ROTUP, steps=10, then load_i=1 with data AA,BB,CC,DD at E3 -> channels = AA,BB,CC,DD; abort_o pulses; done_o never asserts; cmd_ready_o low while load_i is high.
- rst_n pulsed low mid-RUN asynchronously (between edges) -> data_o=0, busy_o=0, done_o=0 immediately. A cmd_valid_i held during reset is accepted on the first edge after release.
